// File: rtl/temporizador_bcd_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
package temporizador_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t MIN_TENS_MAX = 4'd5;
    localparam bcd_t ONES_MAX     = 4'd9;

    // Saturate a preset digit to the largest legal value for its position.
    function automatic bcd_t clamp_bcd(input bcd_t d, input bcd_t mx);
        return (d > mx) ? mx : d;
    endfunction

endpackage

// File: rtl/temporizador_bcd_if.sv
// Command/preset/status bundle between the timer and its controller/display.
interface temporizador_bcd_if;
    logic        tick_in;
    logic        load;
    logic        start;
    logic        stop;
    logic [7:0]  preset_mm;
    logic [7:0]  preset_ss;
    logic [15:0] digits;
    logic        running;
    logic        done;
    logic        alarm;

    modport master (
        output tick_in, load, start, stop, preset_mm, preset_ss,
        input  digits, running, done, alarm
    );

    modport slave (
        input  tick_in, load, start, stop, preset_mm, preset_ss,
        output digits, running, done, alarm
    );
endinterface

// File: rtl/temporizador_bcd_digit_dec.sv
// One BCD digit of the decrement chain: wraps to max when borrowing from zero.
module bcd_digit_dec
    import temporizador_pkg::*;
(
    input  bcd_t digit_i,
    input  bcd_t max_i,
    input  logic borrow_i,
    output bcd_t digit_o,
    output logic borrow_o
);

    // Pass through without borrow; otherwise step down, wrapping 0 -> max.
    always_comb begin
        digit_o  = digit_i;
        borrow_o = 1'b0;
        if (borrow_i) begin
            if (digit_i == 4'd0) begin
                digit_o  = max_i;
                borrow_o = 1'b1;
            end else begin
                digit_o  = digit_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/temporizador_bcd.sv
// MM:SS BCD countdown timer. tick_in is a slow square wave used only as a
// count enable; clock_in is the sole clock.
// Optional feature macro: TEMPORIZADOR_ALARM_EN (post-expiry toggling alarm).
module temporizador_bcd
    import temporizador_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ALARM_TICKS = 10
) (
    input logic               clock_in,
    input logic               reset,
    temporizador_bcd_if.slave bus
);

    if (SYNC_STAGES < 2 || ALARM_TICKS == 0) begin : g_cfg_check
        $error("temporizador_bcd: SYNC_STAGES must be >= 2 and ALARM_TICKS > 0");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q;
    logic                   tick_p;

    state_t      state_q;
    logic [15:0] digits_q;
    logic        running_q;
    logic        done_q;

    logic [15:0] dec_d;
    logic [4:0]  borrow;
    logic [15:0] preset_d;

    // Shift the raw tick into the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.tick_in};
    end

    // Synchroniser and previous-value flop for rising-edge detection.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick_p = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Decrement chain, least significant digit first.
    assign borrow[0] = 1'b1;

    bcd_digit_dec u_sec_o (
        .digit_i (digits_q[3:0]),   .max_i (ONES_MAX),     .borrow_i (borrow[0]),
        .digit_o (dec_d[3:0]),      .borrow_o (borrow[1])
    );
    bcd_digit_dec u_sec_t (
        .digit_i (digits_q[7:4]),   .max_i (SEC_TENS_MAX), .borrow_i (borrow[1]),
        .digit_o (dec_d[7:4]),      .borrow_o (borrow[2])
    );
    bcd_digit_dec u_min_o (
        .digit_i (digits_q[11:8]),  .max_i (ONES_MAX),     .borrow_i (borrow[2]),
        .digit_o (dec_d[11:8]),     .borrow_o (borrow[3])
    );
    bcd_digit_dec u_min_t (
        .digit_i (digits_q[15:12]), .max_i (MIN_TENS_MAX), .borrow_i (borrow[3]),
        .digit_o (dec_d[15:12]),    .borrow_o (borrow[4])
    );

    // Preset digits saturated to legal BCD time values.
    always_comb begin
        preset_d = {clamp_bcd(bus.preset_mm[7:4], MIN_TENS_MAX),
                    clamp_bcd(bus.preset_mm[3:0], ONES_MAX),
                    clamp_bcd(bus.preset_ss[7:4], SEC_TENS_MAX),
                    clamp_bcd(bus.preset_ss[3:0], ONES_MAX)};
    end

`ifdef TEMPORIZADOR_ALARM_EN
    localparam int unsigned ACW = $clog2(ALARM_TICKS + 1);
    localparam logic [ACW-1:0] ALARM_LAST = ACW'(ALARM_TICKS - 1);
    localparam logic [ACW-1:0] ALARM_END  = ACW'(ALARM_TICKS);
    logic           alarm_q;
    logic [ACW-1:0] alarm_cnt_q;
`endif

    // Timer FSM: command priority load > start > stop, registered outputs.
    // borrow[4] only rises when decrementing 00:00, which RUN never holds; it
    // guards against wrapping to 59:59.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            digits_q  <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef TEMPORIZADOR_ALARM_EN
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                state_q   <= IDLE;
                digits_q  <= preset_d;
                running_q <= 1'b0;
`ifdef TEMPORIZADOR_ALARM_EN
                alarm_q     <= 1'b0;
                alarm_cnt_q <= '0;
`endif
            end else begin
                unique case (state_q)
                    IDLE, PAUSE: begin
                        if (bus.start) begin
                            if (digits_q == '0) begin
                                state_q   <= DONE;
                                done_q    <= 1'b1;
                                running_q <= 1'b0;
`ifdef TEMPORIZADOR_ALARM_EN
                                alarm_q     <= 1'b1;
                                alarm_cnt_q <= '0;
`endif
                            end else begin
                                state_q   <= RUN;
                                running_q <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (tick_p && !borrow[4]) begin
                            digits_q <= dec_d;
                        end
                        if (tick_p && !borrow[4] && dec_d == '0) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            running_q <= 1'b0;
`ifdef TEMPORIZADOR_ALARM_EN
                            alarm_q     <= 1'b1;
                            alarm_cnt_q <= '0;
`endif
                        end else if (bus.stop) begin
                            state_q   <= PAUSE;
                            running_q <= 1'b0;
                        end
                    end
                    DONE: begin
`ifdef TEMPORIZADOR_ALARM_EN
                        if (tick_p && alarm_cnt_q < ALARM_END) begin
                            alarm_cnt_q <= alarm_cnt_q + 1'b1;
                            alarm_q     <= (alarm_cnt_q == ALARM_LAST) ? 1'b0 : ~alarm_q;
                        end
`endif
                    end
                endcase
            end
        end
    end

    assign bus.digits  = digits_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
`ifdef TEMPORIZADOR_ALARM_EN
    assign bus.alarm   = alarm_q;
`else
    assign bus.alarm   = 1'b0;
`endif

endmodule

// File: tb/tb_temporizador_bcd.sv
// Directed bench for temporizador_bcd (SYNC_STAGES=2, ALARM_TICKS=4).
module tb_temporizador_bcd;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    temporizador_bcd_if bus ();

    temporizador_bcd #(
        .SYNC_STAGES (2),
        .ALARM_TICKS (4)
    ) dut (
        .clock_in (clk),
        .reset    (rst),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick_rise();
        bus.tick_in = 1'b1;
        step(); step(); step();
    endtask

    task automatic tick_fall();
        bus.tick_in = 1'b0;
        step(); step(); step();
    endtask

    task automatic do_load(input logic [7:0] mm, input logic [7:0] ss);
        bus.preset_mm = mm;
        bus.preset_ss = ss;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.tick_in = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        bus.preset_mm = 8'h00; bus.preset_ss = 8'h00;
        step(); step();
        chk("rst_digits", bus.digits, 16'h0000);
        chk("rst_running", {15'd0, bus.running}, 16'd0);
        chk("rst_done", {15'd0, bus.done}, 16'd0);
        chk("rst_alarm", {15'd0, bus.alarm}, 16'd0);
        rst = 1'b0;
        step();

        // 1: 00:03 countdown to expiry
        do_load(8'h00, 8'h03);
        chk("t1_load", bus.digits, 16'h0003);
        do_start();
        chk("t1_running", {15'd0, bus.running}, 16'd1);
        tick_rise(); chk("t1_tick1", bus.digits, 16'h0002); tick_fall();
        tick_rise(); chk("t1_tick2", bus.digits, 16'h0001); tick_fall();
        tick_rise();
        chk("t1_tick3", bus.digits, 16'h0000);
        chk("t1_done_hi", {15'd0, bus.done}, 16'd1);
        chk("t1_run_lo", {15'd0, bus.running}, 16'd0);
`ifndef TEMPORIZADOR_ALARM_EN
        chk("t1_alarm_off", {15'd0, bus.alarm}, 16'd0);
`endif
        step();
        chk("t1_done_lo", {15'd0, bus.done}, 16'd0);
        tick_fall();

        // 2: borrow chain
        do_load(8'h10, 8'h00); do_start();
        tick_rise(); chk("t2_1000", bus.digits, 16'h0959); tick_fall();
        do_load(8'h01, 8'h00);
        chk("t2_load_idle", {15'd0, bus.running}, 16'd0);
        do_start();
        tick_rise(); chk("t2_0100", bus.digits, 16'h0059); tick_fall();

        // 3: stop coincident with tick
        do_load(8'h00, 8'h45); do_start();
        bus.tick_in = 1'b1;
        step(); step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("t3_stop_dec", bus.digits, 16'h0044);
        chk("t3_paused", {15'd0, bus.running}, 16'd0);
        tick_fall();
        tick_rise(); chk("t3_hold", bus.digits, 16'h0044); tick_fall();
        do_start();
        chk("t3_resume", {15'd0, bus.running}, 16'd1);
        tick_rise(); chk("t3_tick", bus.digits, 16'h0043); tick_fall();

        // 4: clamping and start at zero
        do_load(8'h7C, 8'h9F);
        chk("t4_clamp", bus.digits, 16'h5959);
        do_load(8'h00, 8'h00);
        do_start();
        chk("t4_done_hi", {15'd0, bus.done}, 16'd1);
        chk("t4_run_lo", {15'd0, bus.running}, 16'd0);
        step();
        chk("t4_done_lo", {15'd0, bus.done}, 16'd0);
        do_start();
        chk("t4_ign_start_done", {15'd0, bus.done}, 16'd0);
        chk("t4_ign_start_run", {15'd0, bus.running}, 16'd0);
        tick_rise(); chk("t4_hold0", bus.digits, 16'h0000); tick_fall();

        // 5: async reset mid-run, then tick latency
        do_load(8'h02, 8'h17); do_start();
        chk("t5_running", {15'd0, bus.running}, 16'd1);
        #3 rst = 1'b1;
        #1;
        chk("t5_async_digits", bus.digits, 16'h0000);
        chk("t5_async_run", {15'd0, bus.running}, 16'd0);
        step();
        rst = 1'b0;
        step();
        do_load(8'h00, 8'h10); do_start();
        bus.tick_in = 1'b1;
        step(); chk("t5_lat1", bus.digits, 16'h0010);
        step(); chk("t5_lat2", bus.digits, 16'h0010);
        step(); chk("t5_lat3", bus.digits, 16'h0009);
        tick_fall();

`ifdef TEMPORIZADOR_ALARM_EN
        // 6: alarm active for 4 ticks, load clears it
        do_load(8'h00, 8'h01); do_start();
        tick_rise(); chk("t6_entry", {15'd0, bus.alarm}, 16'd1); tick_fall();
        tick_rise(); chk("t6_a1", {15'd0, bus.alarm}, 16'd0); tick_fall();
        tick_rise(); chk("t6_a2", {15'd0, bus.alarm}, 16'd1); tick_fall();
        tick_rise(); chk("t6_a3", {15'd0, bus.alarm}, 16'd0); tick_fall();
        tick_rise(); chk("t6_a4", {15'd0, bus.alarm}, 16'd0); tick_fall();
        tick_rise(); chk("t6_a5", {15'd0, bus.alarm}, 16'd0); tick_fall();
        do_load(8'h00, 8'h01); do_start();
        tick_rise(); chk("t6_entry2", {15'd0, bus.alarm}, 16'd1); tick_fall();
        do_load(8'h00, 8'h05);
        chk("t6_load_clr", {15'd0, bus.alarm}, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
